// File: rtl/cpu_control_sequencer.sv
// Fetch/decode/execute controller for the eight-bit computer: owns PC and IR, issues datapath strobes.
// Latency 2 cycles (NOP/JMP/LDI/OUT/HLT), 3 (LDA), 4 (ALU ops); each memory cycle with mem_ready low stalls one cycle.
`timescale 1ns/1ps

module cpu_control_sequencer #(
    parameter logic [3:0] RESET_PC      = 4'h0,
    parameter bit         ILLEGAL_HALTS = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_ready,
    input  logic [7:0] mem_rdata,
    output logic       mem_req,
    output logic [3:0] mem_addr,
    output logic [2:0] alu_control,
    output logic       a_load,
    output logic [1:0] a_src,
    output logic       b_load,
    output logic       out_load,
    output logic [3:0] imm,
    output logic       halted,
    output logic [3:0] pc
);

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] ASRC_ALU = 2'b00;
    localparam logic [1:0] ASRC_MEM = 2'b01;
    localparam logic [1:0] ASRC_IMM = 2'b10;

    state_t     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;

    logic [3:0] opcode;
    logic [3:0] operand;

    assign opcode  = ir_q[7:4];
    assign operand = ir_q[3:0];
    assign imm     = operand;
    assign pc      = pc_q;

    function automatic logic [2:0] alu_code(input logic [3:0] op);
        logic [2:0] code;
        code = 3'b000;
        case (op)
            OP_ADD:  code = 3'b001;
            OP_SUB:  code = 3'b010;
            OP_AND:  code = 3'b011;
            OP_OR:   code = 3'b100;
            OP_XOR:  code = 3'b101;
            default: code = 3'b000;
        endcase
        return code;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RESET;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        mem_req     = 1'b0;
        mem_addr    = 4'h0;
        alu_control = 3'b000;
        a_load      = 1'b0;
        a_src       = ASRC_ALU;
        b_load      = 1'b0;
        out_load    = 1'b0;
        halted      = 1'b0;

        case (state_q)
            S_RESET: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 4'd1;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                case (opcode)
                    OP_NOP: state_d = S_FETCH;
                    OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_d = S_MEM;
                    OP_JMP: begin
                        // Overrides the increment applied while this JMP was fetched.
                        pc_d    = operand;
                        state_d = S_FETCH;
                    end
                    OP_LDI: begin
                        a_load  = 1'b1;
                        a_src   = ASRC_IMM;
                        state_d = S_FETCH;
                    end
                    OP_OUT: begin
                        out_load = 1'b1;
                        state_d  = S_FETCH;
                    end
                    OP_HLT: state_d = S_HALT;
                    default: state_d = ILLEGAL_HALTS ? S_HALT : S_FETCH;
                endcase
            end

            S_MEM: begin
                mem_req  = 1'b1;
                mem_addr = operand;
                if (mem_ready) begin
                    if (opcode == OP_LDA) begin
                        a_load  = 1'b1;
                        a_src   = ASRC_MEM;
                        state_d = S_FETCH;
                    end else begin
                        b_load  = 1'b1;
                        state_d = S_EXEC;
                    end
                end
            end

            S_EXEC: begin
                alu_control = alu_code(opcode);
                a_load      = 1'b1;
                a_src       = ASRC_ALU;
                state_d     = S_FETCH;
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = S_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Bench for cpu_control_sequencer: an instruction-level model of the eight-bit computer predicts
// the memory reads and datapath strobes; a monitor compares them as the DUT presents them.
`timescale 1ns/1ps

module tb_cpu_control_sequencer;

    localparam logic [3:0] RST_PC = 4'h0;

    logic       clk;
    logic       rst;
    logic       mem_ready;
    logic [7:0] mem_rdata;
    logic       mem_req;
    logic [3:0] mem_addr;
    logic [2:0] alu_control;
    logic       a_load;
    logic [1:0] a_src;
    logic       b_load;
    logic       out_load;
    logic [3:0] imm;
    logic       halted;
    logic [3:0] pc;

    logic       rst1;
    logic       mem_ready1;
    logic [7:0] mem_rdata1;
    logic       mem_req1;
    logic [3:0] mem_addr1;
    logic [2:0] alu_control1;
    logic       a_load1;
    logic [1:0] a_src1;
    logic       b_load1;
    logic       out_load1;
    logic [3:0] imm1;
    logic       halted1;
    logic [3:0] pc1;

    cpu_control_sequencer #(.RESET_PC(RST_PC), .ILLEGAL_HALTS(1'b0)) dut (
        .clk(clk), .rst(rst), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .alu_control(alu_control),
        .a_load(a_load), .a_src(a_src), .b_load(b_load), .out_load(out_load),
        .imm(imm), .halted(halted), .pc(pc)
    );

    cpu_control_sequencer #(.RESET_PC(RST_PC), .ILLEGAL_HALTS(1'b1)) dut_halts (
        .clk(clk), .rst(rst1), .mem_ready(mem_ready1), .mem_rdata(mem_rdata1),
        .mem_req(mem_req1), .mem_addr(mem_addr1), .alu_control(alu_control1),
        .a_load(a_load1), .a_src(a_src1), .b_load(b_load1), .out_load(out_load1),
        .imm(imm1), .halted(halted1), .pc(pc1)
    );

    logic [7:0]  mem [16];
    int          stall_left [16];
    bit          zero_wait;
    bit          chk_en;
    int          checks;
    int          passes;
    int          cyc;
    int          waits;
    logic [3:0]  addr_q [$];
    logic [11:0] ev_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1, "watchdog");
    end

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail_unexpected(input string name, input logic [31:0] act);
        checks++;
        $display("FAIL %s: got %0h, expected nothing queued", name, act);
    endtask

    function automatic logic [11:0] ev(input logic al, input logic [1:0] src, input logic bl,
                                       input logic ol, input logic [2:0] alu, input logic [3:0] im);
        return {al, src, bl, ol, alu, im};
    endfunction

    // Instruction-level model: walks the programme and lists every completed read and every strobe.
    task automatic model_run(input int limit, output bit halts, output int lat, output logic [3:0] end_pc);
        int p, ins, op, x;
        p = RST_PC;
        halts = 1'b0;
        lat = 0;
        for (int n = 0; n < limit && !halts; n++) begin
            addr_q.push_back(4'(p));
            ins = int'(mem[p[3:0]]);
            p   = (p + 1) % 16;
            op  = ins / 16;
            x   = ins % 16;
            if (op == 1) begin
                addr_q.push_back(4'(x));
                ev_q.push_back(ev(1'b1, 2'd1, 1'b0, 1'b0, 3'd0, 4'(x)));
                lat += 3;
            end else if (op >= 2 && op <= 6) begin
                addr_q.push_back(4'(x));
                ev_q.push_back(ev(1'b0, 2'd0, 1'b1, 1'b0, 3'd0, 4'(x)));
                ev_q.push_back(ev(1'b1, 2'd0, 1'b0, 1'b0, 3'(op - 1), 4'(x)));
                lat += 4;
            end else if (op == 7) begin
                p = x;
                lat += 2;
            end else if (op == 8) begin
                ev_q.push_back(ev(1'b1, 2'd2, 1'b0, 1'b0, 3'd0, 4'(x)));
                lat += 2;
            end else if (op == 14) begin
                ev_q.push_back(ev(1'b0, 2'd0, 1'b0, 1'b1, 3'd0, 4'(x)));
                lat += 2;
            end else if (op == 15) begin
                halts = 1'b1;
                lat += 2;
            end else begin
                lat += 2;
            end
        end
        end_pc = 4'(p);
    endtask

    // Memory responder with random or scripted wait states.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_req && !rst) begin
                if (stall_left[mem_addr] > 0) begin
                    stall_left[mem_addr] = stall_left[mem_addr] - 1;
                    mem_ready = 1'b0;
                end else begin
                    mem_ready = zero_wait ? 1'b1 : ($urandom_range(0, 2) != 0);
                end
                if (!mem_ready) waits++;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            mem_rdata = (mem_req && mem_ready) ? mem[mem_addr] : 8'($urandom);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT completes a read or fires a strobe.
    initial begin
        logic       prev_wait;
        logic [3:0] prev_addr;
        logic [11:0] obs;
        prev_wait = 1'b0;
        prev_addr = 4'h0;
        forever begin
            @(negedge clk);
            #1;
            if (rst || !chk_en) begin
                prev_wait = 1'b0;
            end else begin
                if (prev_wait && mem_req)
                    check("addr_hold", 32'(mem_addr), 32'(prev_addr));
                if (mem_req && mem_ready) begin
                    if (addr_q.size() == 0) fail_unexpected("read_addr", 32'(mem_addr));
                    else check("read_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
                end
                if (a_load || b_load || out_load || alu_control != 3'd0) begin
                    obs = {a_load, a_load ? a_src : 2'b00, b_load, out_load, alu_control, imm};
                    if (ev_q.size() == 0) fail_unexpected("strobe_event", 32'(obs));
                    else check("strobe_event", 32'(obs), 32'(ev_q.pop_front()));
                end
                if (halted)
                    check("halt_quiet", 32'({mem_req, a_load, b_load, out_load, alu_control}), 32'd0);
                prev_wait = mem_req && !mem_ready;
                prev_addr = mem_addr;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check(tag, 32'({mem_req, mem_addr, alu_control, a_load, a_src, b_load, out_load, imm, halted, pc}),
              32'({1'b0, 4'h0, 3'h0, 1'b0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, RST_PC}));
    endtask

    task automatic start_prog(input bit zw, output bit halts, output int lat, output logic [3:0] end_pc);
        rst = 1'b1;
        chk_en = 1'b0;
        @(negedge clk);
        addr_q.delete();
        ev_q.delete();
        zero_wait = zw;
        waits = 0;
        model_run(40, halts, lat, end_pc);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic finish_prog(input string tag, input bit halts, input int lat, input logic [3:0] end_pc);
        int budget;
        budget = 3000;
        if (halts) begin
            while (!halted && budget > 0) begin
                @(negedge clk); #2;
                budget--;
            end
            // One RESET cycle precedes the first fetch; each wait cycle adds one.
            check({tag, "_halt_cycle"}, 32'(cyc), 32'(1 + lat + waits));
            check({tag, "_halt_pc"}, 32'({halted, pc}), 32'({1'b1, end_pc}));
        end else begin
            while ((addr_q.size() != 0 || ev_q.size() != 0) && budget > 0) begin
                @(negedge clk); #2;
                budget--;
            end
        end
        check({tag, "_drained"}, 32'(addr_q.size() + ev_q.size()), 32'd0);
        chk_en = 1'b0;
        foreach (stall_left[i]) stall_left[i] = 0;
    endtask

    initial begin
        bit         halts;
        int         lat;
        logic [3:0] end_pc;
        logic [2:0] hvec;
        int         budget;

        checks = 0;
        passes = 0;
        waits = 0;
        chk_en = 1'b0;
        zero_wait = 1'b1;
        rst = 1'b1;
        rst1 = 1'b1;
        mem_ready1 = 1'b1;
        mem_rdata1 = 8'hA0;
        foreach (mem[i]) mem[i] = 8'h00;
        foreach (stall_left[i]) stall_left[i] = 0;

        repeat (3) @(negedge clk);
        #2;
        check_reset_outputs("reset_state");
        check("reset_state_halts_dut", 32'({mem_req1, halted1, pc1, imm1}), 32'({1'b0, 1'b0, RST_PC, 4'h0}));

        // Undefined opcode 1010 with ILLEGAL_HALTS=1: RESET, FETCH, DECODE, then HALT.
        @(negedge clk);
        rst1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #2;
            hvec[k] = halted1;
        end
        check("illegal_halts", 32'({hvec, pc1}), 32'({3'b100, 4'h1}));

        // LDA 9; ADD A; OUT; HLT with zero wait: halted after 1+3+4+2+2 = 12 edges, pc=4.
        foreach (mem[i]) mem[i] = 8'h00;
        mem[0] = 8'h19; mem[1] = 8'h2A; mem[2] = 8'hE0; mem[3] = 8'hF0;
        mem[9] = 8'h05; mem[10] = 8'h03;
        start_prog(1'b1, halts, lat, end_pc);
        finish_prog("prog_add", halts, lat, end_pc);
        check("prog_add_cycles", 32'(cyc), 32'd12);

        // SUB, AND, OR, XOR each pulse their code for one EXEC cycle.
        foreach (mem[i]) mem[i] = 8'h00;
        mem[0] = 8'h38; mem[1] = 8'h49; mem[2] = 8'h5A; mem[3] = 8'h6B; mem[4] = 8'hF0;
        start_prog(1'b1, halts, lat, end_pc);
        finish_prog("prog_alu", halts, lat, end_pc);

        // Three wait cycles on the fetch at pc=2 and on the operand read at 0xC.
        foreach (mem[i]) mem[i] = 8'h00;
        mem[2] = 8'h2C; mem[3] = 8'hF0;
        stall_left[2] = 3;
        stall_left[12] = 3;
        start_prog(1'b1, halts, lat, end_pc);
        finish_prog("prog_stall", halts, lat, end_pc);
        check("prog_stall_cycles", 32'(cyc), 32'd17);

        // JMP 0x2 at 0xF: pc wraps to 0 on fetch, then becomes 2; also LDI 7 and undefined 1010 as NOP.
        foreach (mem[i]) mem[i] = 8'h00;
        mem[0] = 8'h7F; mem[15] = 8'h72; mem[2] = 8'h87; mem[3] = 8'hA0; mem[4] = 8'hF0;
        start_prog(1'b1, halts, lat, end_pc);
        budget = 50;
        while (!(mem_req && mem_ready && mem_addr == 4'hF) && budget > 0) begin
            @(negedge clk); #2;
            budget--;
        end
        @(negedge clk); #2;
        check("jmp_wrap_pc", 32'(pc), 32'h0);
        @(negedge clk); #2;
        check("jmp_target", 32'({mem_req, mem_addr, pc}), 32'({1'b1, 4'h2, 4'h2}));
        finish_prog("prog_jmp", halts, lat, end_pc);

        // Reset during an operand wait abandons the read with no strobe.
        foreach (mem[i]) mem[i] = 8'h00;
        mem[0] = 8'h1C;
        stall_left[12] = 100;
        rst = 1'b1;
        @(negedge clk);
        addr_q.delete();
        ev_q.delete();
        addr_q.push_back(4'h0);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        budget = 50;
        while (!(mem_req && mem_addr == 4'hC) && budget > 0) begin
            @(negedge clk); #2;
            budget--;
        end
        repeat (2) @(negedge clk);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid_mem");
        check("rst_mid_mem_drained", 32'(addr_q.size() + ev_q.size()), 32'd0);
        chk_en = 1'b0;
        foreach (stall_left[i]) stall_left[i] = 0;
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("rst_release_idle", 32'({mem_req, a_load, b_load, out_load, alu_control}), 32'd0);
        @(negedge clk); #2;
        check("first_fetch_after_rst", 32'({mem_req, mem_addr}), 32'({1'b1, 4'h0}));

        // Random programmes with random wait states; non-halting ones end in an asynchronous reset.
        for (int it = 0; it < 25; it++) begin
            for (int a = 0; a < 16; a++) begin
                int op;
                op = $urandom_range(0, 15);
                if (op == 15 && $urandom_range(0, 2) != 0) op = $urandom_range(0, 14);
                mem[a] = {4'(op), 4'($urandom_range(0, 15))};
            end
            start_prog(it % 4 == 0, halts, lat, end_pc);
            finish_prog("rand", halts, lat, end_pc);
            if (!halts) begin
                repeat ($urandom_range(0, 5)) @(negedge clk);
                @(posedge clk); #3;
                rst = 1'b1;
                #1;
                check_reset_outputs("rand_async_rst");
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
